ula_arb: RTL and testbench

- Shares the single combinational ULA between two requesters: port 0 is the core datapath, port 1 is an auxiliary engine (debug/address-generation).
- Arbitrates round-robin, registers the winner's operands, drives the ULA for one execute cycle, and returns the registered result on that requester's response channel.
- Sits between the requesters and the ULA; the existing ALU-control decoder upstream of each requester supplies the 4-bit ALUCtrl code and the shamt-select flag.

---
 rtl/ula_pkg.sv | 30 +++
 rtl/ula_arb_rr_arb2.sv | 16 +
 rtl/ula_arb.sv | 202 ++++++++++++++++++++
 tb/tb_ula_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sharing arbiter: ALUCtrl codes and FSM states.
package ula_pkg;

  localparam int unsigned CTRL_W = 4;

  // ALUCtrl codes produced by the upstream ALU-control decoder
  localparam logic [CTRL_W-1:0] ALU_AND     = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR      = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD     = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLLV    = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SRLV    = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SRAV    = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SUB     = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT     = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_BNE     = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLL     = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_SRL     = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_XOR     = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_NOR     = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_SRA     = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_ILLEGAL = 4'b1110;
  localparam logic [CTRL_W-1:0] ALU_SLTU    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ula_arb_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   valid0/valid1 : requests
//   ptr           : port that wins when both request
//   grant0_c/1_c  : one-hot (or zero) grant
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic grant0_c,
  output logic grant1_c
);

  assign grant0_c = valid0 & (~valid1 | ~ptr);
  assign grant1_c = valid1 & (~valid0 |  ptr);

endmodule

// File: rtl/ula_arb.sv
// Shares one combinational ULA between the core datapath (port 0) and an
// auxiliary engine (port 1). Round-robin grant in IDLE, one EXEC cycle driving
// the ULA from latched operands, then a held response to the owning port.
//   req*_*  : request channels (ready is combinational from the valids)
//   rsp*_*  : response channels, held until rsp*_ready
//   ula_*   : operands to / result from the external ULA
module ula_arb
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [CTRL_W-1:0]   req0_ctrl,
  input  logic                req0_shsel,
  input  logic [SHW-1:0]      req0_shamt,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [CTRL_W-1:0]   req1_ctrl,
  input  logic                req1_shsel,
  input  logic [SHW-1:0]      req1_shamt,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [WIDTH-1:0]    rsp0_data,
  output logic                rsp0_zero,
  output logic                rsp0_err,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [WIDTH-1:0]    rsp1_data,
  output logic                rsp1_zero,
  output logic                rsp1_err,
  output logic [CTRL_W-1:0]   ula_ctrl,
  output logic                ula_shsel,
  output logic [SHW-1:0]      ula_shamt,
  output logic [WIDTH-1:0]    ula_a,
  output logic [WIDTH-1:0]    ula_b,
  input  logic [WIDTH-1:0]    ula_res,
  input  logic                ula_zero
);

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               shsel_q, shsel_d;
  logic [SHW-1:0]     shamt_q, shamt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d, err_q, err_d;
  logic               rv0_q, rv0_d, rv1_q, rv1_d;

  logic               grant0_c, grant1_c, idle_c, accept_c, rsp_ack_c;
  logic [CTRL_W-1:0]  sel_ctrl_c;
  logic               sel_shsel_c;
  logic [SHW-1:0]     sel_shamt_c;
  logic [WIDTH-1:0]   sel_a_c, sel_b_c;

  rr_arb2 u_arb (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .ptr      (ptr_q),
    .grant0_c (grant0_c),
    .grant1_c (grant1_c)
  );

  // Readys are gated by rst_n so they read 0 while reset is held
  assign idle_c     = rst_n & (state_q == ST_IDLE);
  assign req0_ready = idle_c & grant0_c;
  assign req1_ready = idle_c & grant1_c;
  assign accept_c   = grant0_c | grant1_c;
  assign rsp_ack_c  = owner_q ? rsp1_ready : rsp0_ready;

  // Winner's request fields
  assign sel_ctrl_c  = grant1_c ? req1_ctrl  : req0_ctrl;
  assign sel_shsel_c = grant1_c ? req1_shsel : req0_shsel;
  assign sel_shamt_c = grant1_c ? req1_shamt : req0_shamt;
  assign sel_a_c     = grant1_c ? req1_a     : req0_a;
  assign sel_b_c     = grant1_c ? req1_b     : req0_b;

  // Operand registers double as the ULA drivers: loaded only for a legal
  // accept and cleared at the end of EXEC, so the ULA sees 0 outside EXEC.
  assign ula_ctrl  = ctrl_q;
  assign ula_shsel = shsel_q;
  assign ula_shamt = shamt_q;
  assign ula_a     = a_q;
  assign ula_b     = b_q;

  // One shared result register; only the owner's valid qualifies it
  assign rsp0_valid = rv0_q;
  assign rsp1_valid = rv1_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp0_zero  = zero_q;
  assign rsp1_zero  = zero_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;

  // Next-state and datapath loads
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ctrl_d  = ctrl_q;
    shsel_d = shsel_q;
    shamt_d = shamt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    rv0_d   = rv0_q;
    rv1_d   = rv1_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          owner_d = grant1_c;
          ptr_d   = ~grant1_c;
          if (sel_ctrl_c == ALU_ILLEGAL) begin
            state_d = ST_RESP;
            res_d   = '0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
            rv0_d   = ~grant1_c;
            rv1_d   = grant1_c;
          end else begin
            state_d = ST_EXEC;
            ctrl_d  = sel_ctrl_c;
            shsel_d = sel_shsel_c;
            shamt_d = sel_shamt_c;
            a_d     = sel_a_c;
            b_d     = sel_b_c;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        res_d   = ula_res;
        zero_d  = ula_zero;
        err_d   = 1'b0;
        rv0_d   = ~owner_q;
        rv1_d   = owner_q;
        ctrl_d  = '0;
        shsel_d = 1'b0;
        shamt_d = '0;
        a_d     = '0;
        b_d     = '0;
      end
      ST_RESP: begin
        if (rsp_ack_c) begin
          state_d = ST_IDLE;
          rv0_d   = 1'b0;
          rv1_d   = 1'b0;
          res_d   = '0;
          zero_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      ctrl_q  <= '0;
      shsel_q <= 1'b0;
      shamt_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ctrl_q  <= ctrl_d;
      shsel_q <= shsel_d;
      shamt_q <= shamt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

endmodule

// File: tb/tb_ula_arb.sv
// Bench for ula_arb: behavioural ULA, transaction-level expectation model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ula_arb;
  import ula_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_ready, req0_shsel;
  logic [3:0]        req0_ctrl;
  logic [SHW-1:0]    req0_shamt;
  logic [WIDTH-1:0]  req0_a, req0_b;
  logic              req1_valid, req1_ready, req1_shsel;
  logic [3:0]        req1_ctrl;
  logic [SHW-1:0]    req1_shamt;
  logic [WIDTH-1:0]  req1_a, req1_b;
  logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic [WIDTH-1:0]  rsp0_data;
  logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [WIDTH-1:0]  rsp1_data;
  logic [3:0]        ula_ctrl;
  logic              ula_shsel, ula_zero;
  logic [SHW-1:0]    ula_shamt;
  logic [WIDTH-1:0]  ula_a, ula_b, ula_res;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  ula_arb #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_shsel(req0_shsel), .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_shsel(req1_shsel), .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .ula_ctrl(ula_ctrl), .ula_shsel(ula_shsel), .ula_shamt(ula_shamt),
    .ula_a(ula_a), .ula_b(ula_b), .ula_res(ula_res), .ula_zero(ula_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural ULA
  function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] c, input logic sh,
      input logic [SHW-1:0] sa_in, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sa;
    sa = sh ? sa_in : a[SHW-1:0];
    case (c)
      ALU_AND:                return a & b;
      ALU_OR:                 return a | b;
      ALU_ADD:                return a + b;
      ALU_SUB, ALU_BNE:       return a - b;
      ALU_SLT:                return WIDTH'($signed(a) < $signed(b));
      ALU_SLTU:               return WIDTH'(a < b);
      ALU_XOR:                return a ^ b;
      ALU_NOR:                return ~(a | b);
      ALU_SLL, ALU_SLLV:      return b << sa;
      ALU_SRL, ALU_SRLV:      return b >> sa;
      ALU_SRA, ALU_SRAV:      return WIDTH'($signed(b) >>> sa);
      default:                return '0;
    endcase
  endfunction

  assign ula_res  = alu_model(ula_ctrl, ula_shsel, ula_shamt, ula_a, ula_b);
  assign ula_zero = (ula_res == '0);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Transaction model: at most one op in flight, ties go to the port that did not win last
  logic             m_busy, m_owner, m_last, m_legal, m_sh, m_zero;
  logic [3:0]       m_ctrl;
  logic [SHW-1:0]   m_sa;
  logic [WIDTH-1:0] m_a, m_b, m_res;
  int               m_tacc;

  always @(negedge clk) begin : model
    logic e_r0, e_r1, e_exec, e_v, e_v0, e_v1;
    int age;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      chk("rst req0_ready", 32'(req0_ready), 32'd0);
      chk("rst req1_ready", 32'(req1_ready), 32'd0);
      chk("rst rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst ula_ctrl",   32'(ula_ctrl),   32'd0);
      chk("rst ula_a",      32'(ula_a),      32'd0);
      chk("rst rsp0_data",  32'(rsp0_data),  32'd0);
      chk("rst rsp0_err",   32'(rsp0_err),   32'd0);
    end else begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          e_r0 = m_last;
          e_r1 = !m_last;
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      age    = cycle - m_tacc;
      e_exec = m_busy && m_legal && (age == 1);
      e_v    = m_busy && (age >= (m_legal ? 2 : 1));
      e_v0   = e_v && !m_owner;
      e_v1   = e_v && m_owner;
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
      chk("ula_ctrl",  32'(ula_ctrl),  e_exec ? 32'(m_ctrl)  : 32'd0);
      chk("ula_shsel", 32'(ula_shsel), e_exec ? 32'(m_sh)    : 32'd0);
      chk("ula_shamt", 32'(ula_shamt), e_exec ? 32'(m_sa)    : 32'd0);
      chk("ula_a",     32'(ula_a),     e_exec ? 32'(m_a)     : 32'd0);
      chk("ula_b",     32'(ula_b),     e_exec ? 32'(m_b)     : 32'd0);
      if (e_v0) begin
        chk("rsp0_data", 32'(rsp0_data), 32'(m_res));
        chk("rsp0_zero", 32'(rsp0_zero), 32'(m_zero));
        chk("rsp0_err",  32'(rsp0_err),  32'(!m_legal));
      end
      if (e_v1) begin
        chk("rsp1_data", 32'(rsp1_data), 32'(m_res));
        chk("rsp1_zero", 32'(rsp1_zero), 32'(m_zero));
        chk("rsp1_err",  32'(rsp1_err),  32'(!m_legal));
      end
      if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) m_busy = 1'b0;
      if ((e_r0 && req0_valid) || (e_r1 && req1_valid)) begin
        m_owner = e_r1;
        m_last  = e_r1;
        m_tacc  = cycle;
        m_ctrl  = e_r1 ? req1_ctrl  : req0_ctrl;
        m_sh    = e_r1 ? req1_shsel : req0_shsel;
        m_sa    = e_r1 ? req1_shamt : req0_shamt;
        m_a     = e_r1 ? req1_a     : req0_a;
        m_b     = e_r1 ? req1_b     : req0_b;
        m_legal = (m_ctrl != ALU_ILLEGAL);
        m_res   = m_legal ? alu_model(m_ctrl, m_sh, m_sa, m_a, m_b) : '0;
        m_zero  = m_legal && (m_res == '0);
        m_busy  = 1'b1;
      end
    end
  end

  task automatic set_req(input int p, input logic [3:0] c, input logic sh,
                         input logic [SHW-1:0] sa, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (p == 1) begin
      req1_ctrl = c; req1_shsel = sh; req1_shamt = sa; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_ctrl = c; req0_shsel = sh; req0_shamt = sa; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
  endtask

  // Call at a negedge; returns the accept cycle, with valid dropped just after the accept edge
  task automatic wait_acc(input int p, output int t);
    int n;
    n = 0;
    while (!((p == 1) ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout port %0d: no ready within 40 cycles", p);
    end
    t = cycle;
    @(posedge clk); #1;
    if (p == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, th;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_ctrl = '0; req0_shsel = 1'b0; req0_shamt = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctrl = '0; req1_shsel = 1'b0; req1_shamt = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ADD on port 0
    set_req(0, ALU_ADD, 1'b0, 5'd0, 32'd5, 32'd7);
    @(negedge clk);
    wait_acc(0, t);
    @(negedge clk);
    chk("add ula_ctrl", 32'(ula_ctrl), 32'b0010);
    chk("add ula_a", ula_a, 32'd5);
    chk("add ula_b", ula_b, 32'd7);
    @(negedge clk);
    chk("add latency", 32'(cycle - t), 32'd2);
    chk("add rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("add rsp0_data", rsp0_data, 32'd12);
    chk("add rsp0_zero", 32'(rsp0_zero), 32'd0);
    chk("add rsp0_err", 32'(rsp0_err), 32'd0);

    // Tie from reset: port 0 first, then port 1, then port 0 again
    @(posedge clk); #1 rst_n = 1'b0;
    set_req(0, ALU_SUB, 1'b0, 5'd0, 32'd9, 32'd9);
    set_req(1, ALU_OR,  1'b0, 5'd0, 32'd3, 32'd4);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("tie1 req0_ready", 32'(req0_ready), 32'd1);
    chk("tie1 req1_ready", 32'(req1_ready), 32'd0);
    wait_acc(0, t);
    @(negedge clk); @(negedge clk);
    chk("tie1 rsp0_data", rsp0_data, 32'd0);
    chk("tie1 rsp0_zero", 32'(rsp0_zero), 32'd1);
    @(negedge clk);
    wait_acc(1, t);
    @(negedge clk); @(negedge clk);
    chk("tie2 rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("tie2 rsp1_data", rsp1_data, 32'd7);
    @(posedge clk); #1;
    set_req(0, ALU_AND, 1'b0, 5'd0, 32'hff, 32'h0f);
    set_req(1, ALU_ADD, 1'b0, 5'd0, 32'd1, 32'd1);
    @(negedge clk);
    chk("tie3 req0_ready", 32'(req0_ready), 32'd1);
    chk("tie3 req1_ready", 32'(req1_ready), 32'd0);
    wait_acc(0, t);
    @(negedge clk); @(negedge clk);
    chk("tie3 rsp0_data", rsp0_data, 32'h0f);
    @(negedge clk);
    wait_acc(1, t);
    @(negedge clk); @(negedge clk);
    chk("tie4 rsp1_data", rsp1_data, 32'd2);

    // Backpressure on port 1 while port 0 waits
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    set_req(1, ALU_ADD, 1'b0, 5'd0, 32'd100, 32'd23);
    @(negedge clk);
    wait_acc(1, t);
    set_req(0, ALU_XOR, 1'b0, 5'd0, 32'hf0, 32'hff);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("bp rsp1_data", rsp1_data, 32'd123);
      chk("bp req0_ready", 32'(req0_ready), 32'd0);
    end
    @(posedge clk); #1 rsp1_ready = 1'b1;
    @(negedge clk);
    th = cycle;
    chk("bp hs req0_ready", 32'(req0_ready), 32'd0);
    wait_acc(0, t);
    chk("bp accept after hs", 32'(t - th), 32'd1);
    @(negedge clk); @(negedge clk);
    chk("bp rsp0_data", rsp0_data, 32'h0f);

    // Illegal code on port 1, then a legal op
    @(posedge clk); #1;
    set_req(1, ALU_ILLEGAL, 1'b0, 5'd0, 32'd1, 32'd2);
    @(negedge clk);
    wait_acc(1, t);
    @(negedge clk);
    chk("ill latency", 32'(cycle - t), 32'd1);
    chk("ill rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("ill rsp1_err", 32'(rsp1_err), 32'd1);
    chk("ill rsp1_data", rsp1_data, 32'd0);
    chk("ill ula_ctrl", 32'(ula_ctrl), 32'd0);
    @(posedge clk); #1;
    set_req(1, ALU_AND, 1'b0, 5'd0, 32'hf0, 32'h3c);
    @(negedge clk);
    wait_acc(1, t);
    @(negedge clk);
    chk("post-ill ula_a", ula_a, 32'hf0);
    @(negedge clk);
    chk("post-ill rsp1_data", rsp1_data, 32'h30);
    chk("post-ill rsp1_err", 32'(rsp1_err), 32'd0);

    // Shift by shamt
    @(posedge clk); #1;
    set_req(0, ALU_SLL, 1'b1, 5'd4, 32'd0, 32'd1);
    @(negedge clk);
    wait_acc(0, t);
    @(negedge clk);
    chk("sll ula_ctrl", 32'(ula_ctrl), 32'b1001);
    chk("sll ula_shsel", 32'(ula_shsel), 32'd1);
    chk("sll ula_shamt", 32'(ula_shamt), 32'd4);
    @(negedge clk);
    chk("sll rsp0_data", rsp0_data, 32'd16);

    // Reset during EXEC
    @(posedge clk); #1;
    set_req(0, ALU_ADD, 1'b0, 5'd0, 32'd3, 32'd4);
    @(negedge clk);
    wait_acc(0, t);
    #1;
    chk("mid ula_ctrl pre", 32'(ula_ctrl), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid ula_ctrl async", 32'(ula_ctrl), 32'd0);
    chk("mid ula_a async", ula_a, 32'd0);
    chk("mid rsp0_valid async", 32'(rsp0_valid), 32'd0);
    set_req(0, ALU_OR, 1'b0, 5'd0, 32'd1, 32'd2);
    set_req(1, ALU_OR, 1'b0, 5'd0, 32'd4, 32'd8);
    @(negedge clk);
    chk("mid rsp0_valid", 32'(rsp0_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid tie req0_ready", 32'(req0_ready), 32'd1);
    chk("mid tie req1_ready", 32'(req1_ready), 32'd0);
    wait_acc(0, t);
    @(negedge clk); @(negedge clk);
    chk("mid rsp0_data", rsp0_data, 32'd3);
    @(negedge clk);
    wait_acc(1, t);
    @(negedge clk); @(negedge clk);
    chk("mid rsp1_data", rsp1_data, 32'd12);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
